truth_table_sweeper: RTL and testbench

- Stimulus-and-capture stage placed directly upstream of a 4-input combinational logic block under test.
- Sweeps all 16 input combinations onto the DUT inputs and waits a programmable settle time before sampling the DUT output for each combination.
- Assembles the sampled outputs into a 16-bit truth-table word and compares it against a golden word, reporting a mismatch count and the first failing index.
- Replaces hand-written exhaustive testbench loops; usable in simulation and on a board.

---
 rtl/tt_pkg.sv | 23 ++
 rtl/tt_settle_timer.sv | 43 ++++
 rtl/truth_table_sweeper.sv | 178 +++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared types and sizing for the truth-table sweeper.
//   tt_state_t : sweeper FSM state encoding
//   N_VEC      : number of input vectors swept (4-input block => 16)
//   IDX_W      : width of the vector index / dut_in
//   CNT_W      : width of the settle timer and of the mismatch counter
//                (5 bits so a full 16-vector miss count cannot overflow)
// -----------------------------------------------------------------------------
package tt_pkg;

    localparam int N_VEC = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

endpackage : tt_pkg

// File: rtl/tt_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_settle_timer
// Down-counter that measures how long a vector has been held on the block
// under test. Loading presets it to SETTLE_CYCLES-1; each enabled cycle counts
// down; expired is the terminal-count compare (count == 0). With a preset of
// SETTLE_CYCLES-1, expired is seen in the SETTLE_CYCLES-th settle cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   preset the counter for a new vector
//   en       in   count down by one
//   expired  out  settle time has elapsed (terminal count reached)
// -----------------------------------------------------------------------------
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] PRESET = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= PRESET;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule : tt_settle_timer

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives all 16 input combinations into a 4-input combinational block, holds
// each for SETTLE_CYCLES cycles, samples the block output, and builds a 16-bit
// truth table that is compared against EXPECTED.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; dut_in parked at 0; results held
//   SETTLE | vector idx on dut_in, waiting for the block to settle
//   SAMPLE | capture dut_out into table_out[idx], update miss tracking
//   DONE   | one-cycle done pulse; match reflects the finished sweep
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   sweep request, honoured only in IDLE
//   abort        in   cancel a running sweep (SETTLE/SAMPLE only)
//   dut_out      in   output of the block under test
//   dut_in       out  vector to the block, {a,b,c,d}, a = MSB
//   busy         out  sweep in progress (SETTLE or SAMPLE)
//   done         out  one-cycle pulse on normal completion
//   table_out    out  captured truth table, bit i = output for vector i
//   match        out  table_out == EXPECTED, valid from the done pulse on
//   mismatch_cnt out  number of bits differing from EXPECTED
//   first_fail   out  lowest failing vector index (0 if none)
//   fail_valid   out  at least one mismatch recorded
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int              SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0] EXPECTED     = 16'h6996
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_out,
    output logic [IDX_W-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] table_out,
    output logic             match,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [IDX_W-1:0] first_fail,
    output logic             fail_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

    tt_state_t        state_q;
    tt_state_t        state_d;
    logic [IDX_W-1:0] idx_q;

    logic             timer_load;
    logic             timer_en;
    logic             timer_expired;

    logic             miss;
    logic [CNT_W-1:0] mismatch_cnt_next;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort is deliberately not looked at here, so start wins.
                if (start) begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_expired) begin
                    state_d = SAMPLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------- capture and compare
    assign miss              = (dut_out != EXPECTED[idx_q]);
    assign mismatch_cnt_next = mismatch_cnt + CNT_W'(miss);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            table_out    <= '0;
            match        <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q        <= '0;
                        table_out    <= '0;
                        match        <= 1'b0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        fail_valid   <= 1'b0;
                    end
                end
                SAMPLE: begin
                    // An abort in the sample cycle discards this vector.
                    if (!abort) begin
                        table_out[idx_q] <= dut_out;
                        if (miss) begin
                            mismatch_cnt <= mismatch_cnt_next;
                            if (!fail_valid) begin
                                first_fail <= idx_q;
                                fail_valid <= 1'b1;
                            end
                        end
                        // match is resolved from the final count on the way
                        // into DONE so it is already valid while done is high.
                        if (idx_q == LAST_IDX) begin
                            match <= (mismatch_cnt_next == '0);
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All outputs below derive from registers only; dut_out never reaches
    // an output combinationally.
    assign busy   = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done   = (state_q == DONE);
    assign dut_in = busy ? idx_q : '0;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    localparam logic [15:0] GOLD = 16'h6996;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        start, abort;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy, done, match, fail_valid;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;

    logic        start_b, abort_b;
    logic [3:0]  dut_in_b;
    logic        dut_out_b;
    logic        busy_b, done_b, match_b, fail_valid_b;
    logic [15:0] table_b;
    logic [4:0]  mcnt_b;
    logic [3:0]  ff_b;

    int          mode_r = 0;
    logic [15:0] tt_r   = 16'h0000;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    int done_pulses_b = 0;

    // Behavioural model of the block under test.
    // mode 0: parity, 1: constant one, 2: follows input a, 3: arbitrary table.
    function automatic logic model_out(input int mode, input logic [3:0] v, input logic [15:0] rt);
        case (mode)
            0:       return ^v;
            1:       return 1'b1;
            2:       return v[3];
            default: return rt[v];
        endcase
    endfunction

    // Truth table expected after the first n vectors have been captured.
    function automatic logic [15:0] model_table(input int mode, input logic [15:0] rt, input int n);
        logic [15:0] t = '0;
        for (int i = 0; i < n; i++) t[i] = model_out(mode, 4'(i), rt);
        return t;
    endfunction

    function automatic int model_misses(input logic [15:0] t, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (t[i] != GOLD[i]) c++;
        return c;
    endfunction

    function automatic int model_first(input logic [15:0] t, input int n);
        for (int i = 0; i < n; i++) if (t[i] != GOLD[i]) return i;
        return 0;
    endfunction

    assign dut_out   = model_out(mode_r, dut_in, tt_r);
    assign dut_out_b = ^dut_in_b;

    truth_table_sweeper u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .dut_out      (dut_out),
        .dut_in       (dut_in),
        .busy         (busy),
        .done         (done),
        .table_out    (table_out),
        .match        (match),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail),
        .fail_valid   (fail_valid)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_b),
        .abort        (abort_b),
        .dut_out      (dut_out_b),
        .dut_in       (dut_in_b),
        .busy         (busy_b),
        .done         (done_b),
        .table_out    (table_b),
        .match        (match_b),
        .mismatch_cnt (mcnt_b),
        .first_fail   (ff_b),
        .fail_valid   (fail_valid_b)
    );

    always @(posedge clk) begin
        if (done)   done_pulses   <= done_pulses + 1;
        if (done_b) done_pulses_b <= done_pulses_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic [15:0] t, input int n, input logic exp_match);
        check({tag, " table_out"},    32'(table_out),    32'(t));
        check({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'(model_misses(t, n)));
        check({tag, " first_fail"},   32'(first_fail),   32'(model_first(t, n)));
        check({tag, " fail_valid"},   32'(fail_valid),   32'(model_misses(t, n) != 0));
        check({tag, " match"},        32'(match),        32'(exp_match));
    endtask

    // Full sweep on the default instance: checks latency, dut_in stepping,
    // results during the done pulse, and one-cycle done width.
    task automatic run_sweep(input string tag, input int mode, input logic [15:0] rt, input logic with_abort);
        int          s;
        int          p0;
        bit          got;
        bit          seq_ok;
        logic [15:0] t;
        mode_r = mode;
        tt_r   = rt;
        t      = model_table(mode, rt, 16);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        s     = cyc;
        p0    = done_pulses;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        got    = 1'b0;
        seq_ok = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            if (done) got = 1'b1;
            else begin
                if (dut_in !== 4'((cyc - s - 1) / 3)) seq_ok = 1'b0;
                @(negedge clk);
            end
        end
        check({tag, " done seen"},    32'(got),     32'd1);
        check({tag, " done cycle"},   32'(cyc - s), 32'd49);
        check({tag, " dut_in steps"}, 32'(seq_ok),  32'd1);
        check_results(tag, t, 16, (t == GOLD));
        @(negedge clk);
        check({tag, " done width"},  32'(done),        32'd0);
        check({tag, " done pulses"}, 32'(done_pulses), 32'(p0 + 1));
        check({tag, " held table"},  32'(table_out),   32'(t));
    endtask

    // Wait (bounded) for the default instance to present vector v.
    task automatic wait_vec(input string tag, input logic [3:0] v);
        int n = 0;
        while (dut_in !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " reached vector"}, 32'(dut_in), 32'(v));
    endtask

    initial begin
        int          p0;
        int          v;
        int          ph;
        int          s;
        bit          got;
        bit          seq_ok;
        logic [15:0] rt;
        logic [15:0] t;

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dut_in",       32'(dut_in),       32'd0);
        check("reset busy",         32'(busy),         32'd0);
        check("reset done",         32'(done),         32'd0);
        check("reset table_out",    32'(table_out),    32'd0);
        check("reset match",        32'(match),        32'd0);
        check("reset mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        check("reset first_fail",   32'(first_fail),   32'd0);
        check("reset fail_valid",   32'(fail_valid),   32'd0);
        rst_n = 1'b1;

        run_sweep("parity",   0, 16'h0000, 1'b0);
        run_sweep("const1",   1, 16'h0000, 1'b0);
        run_sweep("follow_a", 2, 16'h0000, 1'b0);
        run_sweep("start+abort idle", 0, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            rt = 16'($urandom);
            run_sweep("random table", 3, rt, 1'b0);
        end

        // Re-pulsed start ignored, abort in SETTLE of vector 9.
        mode_r = 0;
        p0     = done_pulses;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec("abort9", 4'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec("abort9", 4'd9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort9 busy",   32'(busy),   32'd0);
        check("abort9 dut_in", 32'(dut_in), 32'd0);
        check_results("abort9", model_table(0, 16'h0, 9), 9, 1'b0);
        repeat (3) @(negedge clk);
        check("abort9 no done", 32'(done_pulses), 32'(p0));

        // Random abort point; phase 2 lands on the SAMPLE cycle, where abort
        // must win over capture.
        for (int k = 0; k < 4; k++) begin
            rt     = 16'($urandom);
            v      = int'($urandom_range(15, 1));
            ph     = int'($urandom_range(2, 0));
            mode_r = 3;
            tt_r   = rt;
            p0     = done_pulses;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_vec("rand abort", 4'(v));
            repeat (ph) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("rand abort busy", 32'(busy), 32'd0);
            check_results("rand abort", model_table(3, rt, v), v, 1'b0);
            @(negedge clk);
            check("rand abort no done", 32'(done_pulses), 32'(p0));
        end

        // Reset during vector 7.
        mode_r = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec("midreset", 4'd7);
        #2 rst_n = 1'b0;
        #1;
        check("midreset dut_in",       32'(dut_in),       32'd0);
        check("midreset busy",         32'(busy),         32'd0);
        check("midreset done",         32'(done),         32'd0);
        check("midreset table_out",    32'(table_out),    32'd0);
        check("midreset mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        check("midreset fail_valid",   32'(fail_valid),   32'd0);
        check("midreset first_fail",   32'(first_fail),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("after reset", 0, 16'h0000, 1'b0);

        // SETTLE_CYCLES=1 instance: each vector held exactly 2 cycles.
        @(negedge clk);
        start_b = 1'b1;
        s       = cyc;
        p0      = done_pulses_b;
        @(negedge clk);
        start_b = 1'b0;
        got     = 1'b0;
        seq_ok  = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            if (done_b) got = 1'b1;
            else begin
                if (dut_in_b !== 4'((cyc - s - 1) / 2)) seq_ok = 1'b0;
                @(negedge clk);
            end
        end
        check("s1 done seen",    32'(got),      32'd1);
        check("s1 done cycle",   32'(cyc - s),  32'd33);
        check("s1 dut_in steps", 32'(seq_ok),   32'd1);
        check("s1 table_out",    32'(table_b),  32'(model_table(0, 16'h0, 16)));
        check("s1 match",        32'(match_b),  32'd1);
        check("s1 mismatch_cnt", 32'(mcnt_b),   32'd0);
        @(negedge clk);
        check("s1 done pulses",  32'(done_pulses_b), 32'(p0 + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_truth_table_sweeper
